// File: rtl/spi_pkg.sv
// Shared encodings for the SPI slave controller: FSM states and command codes.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHK_CMD   = 3'd1,
    ST_WRITE     = 3'd2,
    ST_READ_ADD  = 3'd3,
    ST_READ_DATA = 3'd4
  } spi_state_e;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } spi_cmd_e;

endpackage

// File: rtl/spi_piso.sv
// Parallel-to-serial shifter driving MISO, MSB first; output is 0 whenever idle.
module spi_piso #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  output logic              serial,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_W);

  logic [DATA_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              out_q, out_d;

  assign busy   = (cnt_q != '0);
  assign serial = out_q;

  // The first bit appears one cycle after the load edge.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    out_d = 1'b0;
    if (clear) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (busy) begin
      out_d = sr_q[DATA_W-1];
      sr_d  = {sr_q[DATA_W-2:0], 1'b0};
      cnt_d = cnt_q - 1'b1;
    end else if (load) begin
      sr_d  = data;
      cnt_d = CNT_LOAD;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave frame receiver: {cmd[1:0], payload} frames on MOSI, read data returned on MISO.
module spi_slave_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SS_n,
  input  logic              MOSI,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  output logic              MISO
);

  localparam int FRAME_W = DATA_W + 2;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);

  spi_state_e         state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [FRAME_W-1:0] rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               rd_addr_done_q, rd_addr_done_d;

  logic               frame_done;
  logic [FRAME_W-1:0] frame_shift;
  logic               piso_load;
  logic               piso_busy;

  assign frame_done  = (bit_cnt_q == CNT_FULL);
  assign frame_shift = {frame_q[FRAME_W-2:0], MOSI};
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;

  // Abort on SS_n high outranks everything, including the final frame bit.
  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    frame_d        = frame_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rd_addr_done_d = rd_addr_done_q;
    if (state_q != ST_IDLE && SS_n) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      frame_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: if (!SS_n) state_d = ST_CHK_CMD;
        ST_CHK_CMD: begin
          frame_d   = {{(FRAME_W-1){1'b0}}, MOSI};
          bit_cnt_d = CNT_ONE;
          if (!MOSI)               state_d = ST_WRITE;
          else if (rd_addr_done_q) state_d = ST_READ_DATA;
          else                     state_d = ST_READ_ADD;
        end
        ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
          if (!frame_done) begin
            frame_d   = frame_shift;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == CNT_LAST) begin
              rx_data_d  = frame_shift;
              rx_valid_d = 1'b1;
              if (state_q == ST_READ_ADD)  rd_addr_done_d = 1'b1;
              if (state_q == ST_READ_DATA) rd_addr_done_d = 1'b0;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      bit_cnt_q      <= '0;
      frame_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rd_addr_done_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      frame_q        <= frame_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rd_addr_done_q <= rd_addr_done_d;
    end
  end

  assign piso_load = tx_valid && !SS_n && (state_q == ST_READ_DATA) && frame_done && !piso_busy;

  spi_piso #(
    .DATA_W (DATA_W)
  ) u_piso (
    .clk    (clk),
    .rst    (rst),
    .clear  (SS_n),
    .load   (piso_load),
    .data   (tx_data),
    .serial (MISO),
    .busy   (piso_busy)
  );

endmodule

// File: doc/spi_slave_ctrl.md
SPI_SLAVE_CTRL -- requirements
Module: spi_slave_ctrl

Interface
REQ-001 Parameter DATA_W, default 8: payload width; frame width FRAME_W = DATA_W+2 (2 command bits + payload).
REQ-002 clk  input  1  single clock; MOSI sampled and MISO driven on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 SS_n  input  1  slave select, active low; high = bus idle / frame abort.
REQ-005 MOSI  input  1  serial data from master, MSB first.
REQ-006 tx_valid  input  1  one-cycle strobe: tx_data holds read data for the master.
REQ-007 tx_data  input  DATA_W  read data to serialise onto MISO.
REQ-008 rx_data  output  FRAME_W  last complete received frame {cmd[1:0], payload}.
REQ-009 rx_valid  output  1  one-cycle pulse: rx_data newly updated.
REQ-010 MISO  output  1  serial read data to master, MSB first; 0 when not shifting.

Function
REQ-011 States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA; internal flag rd_addr_done.
REQ-012 IDLE: SS_n low -> CHK_CMD; otherwise stay.
REQ-013 CHK_CMD: samples MOSI as frame bit FRAME_W-1; MOSI=0 -> WRITE; MOSI=1, rd_addr_done=0 -> READ_ADD; MOSI=1, rd_addr_done=1 -> READ_DATA.
REQ-014 WRITE/READ_ADD/READ_DATA: shift one MOSI bit per cycle into the frame register until FRAME_W bits total (including the CHK_CMD bit) are captured.
REQ-015 On capture of bit FRAME_W (bit 0), rx_data is loaded with the full frame and rx_valid is high for exactly that one cycle.
REQ-016 Bits arriving after a complete frame, while SS_n stays low, are ignored; rx_valid is not asserted again and the state is held.
REQ-017 A completed READ_ADD frame sets rd_addr_done=1; a completed READ_DATA frame clears it; WRITE does not change it.
REQ-018 The second command bit is not decoded; it is passed through in rx_data[FRAME_W-2].
REQ-019 In READ_DATA after frame completion, the first tx_valid latches tx_data; MISO drives tx_data[DATA_W-1] on the following cycle, then one bit per cycle down to bit 0, then 0.
REQ-020 tx_valid is ignored in any state other than completed READ_DATA, and while MISO shifting is in progress.
REQ-021 SS_n high in any non-IDLE state -> IDLE on the next edge: partial frame discarded (no rx_valid), bit counter cleared, MISO shifting aborted to 0, rd_addr_done kept.
REQ-022 SS_n high in the same cycle as the final frame bit: frame is discarded, abort takes priority.
REQ-023 rx_data holds its value between frames; it changes only on rx_valid.

Reset
REQ-024 rst low asynchronously forces: state=IDLE, rx_data=0, rx_valid=0, MISO=0, rd_addr_done=0, bit and shift counters=0, shift registers=0.
REQ-025 Reset mid-frame discards all partial data; first frame after release decodes as write/read-address normally.

Structure
REQ-026 Shared package spi_pkg holds the state encodings (3-bit) and command codes (00 wr addr, 01 wr data, 10 rd addr, 11 rd data).
REQ-027 One sub-module, spi_piso (DATA_W-parameterised parallel-to-serial with load strobe and busy), generates MISO; bit counter width is $clog2(FRAME_W+1).

Verification (DATA_W=8 unless stated)
REQ-028 SS_n low, MOSI 00_1010_0101 -> rx_data=10'h0A5, rx_valid one cycle, rd_addr_done=0.
REQ-029 Frame 10_0000_0011, SS_n high, frame 11_0000_0000, then tx_valid with tx_data=8'hC3 -> rx_data 10'h203 then 10'h300, MISO 1,1,0,0,0,0,1,1 then 0, rd_addr_done=0.
REQ-030 SS_n high after 5 bits -> no rx_valid, IDLE next cycle, rx_data unchanged; following frame 01_1111_0000 -> rx_data=10'h1F0.
REQ-031 rst low during MISO bit 3 -> MISO=0 and state IDLE immediately, rd_addr_done=0.
REQ-032 DATA_W=16, frame 01 followed by 16'hBEEF -> rx_data=18'h1BEEF, rx_valid after 18 sampled bits.
REQ-033 20 MOSI bits with SS_n held low after a write frame -> exactly one rx_valid pulse.
